// File: rtl/slot_machine_multi.sv
// Multi-reel slot machine: coin-fed credit counter, LFSR-driven reels that lock one at a time.
// Optional early stop via the lever during a spin when SLOT_EARLY_STOP_EN is defined.
module slot_machine_multi #(
    parameter int NUM_REELS   = 3,
    parameter int SYM_W       = 3,
    parameter int SPIN_CYCLES = 8,
    parameter int CREDIT_W    = 8,
    parameter int PAYOUT      = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       lever,
    input  logic                       coin,
    output logic [NUM_REELS*SYM_W-1:0] reels,
    output logic [CREDIT_W-1:0]        credits,
    output logic                       busy,
    output logic                       win
);

    localparam int CNT_W = $clog2(SPIN_CYCLES);
    localparam int IDX_W = $clog2(NUM_REELS + 1);
    localparam int SUM_W = CREDIT_W + 33;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REELS - 1);
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'({CREDIT_W{1'b1}});
    localparam logic [SUM_W-1:0] PAYOUT_EXT = SUM_W'(PAYOUT);

    typedef enum logic [1:0] {IDLE, SPIN, EVAL, WIN} state_t;

    state_t             state;
    state_t             state_next;
    logic               lever_q;
    logic               lever_rise;
    logic [15:0]        lfsr;
    logic               lfsr_fb;
    logic [CNT_W-1:0]   spin_cnt;
    logic [IDX_W-1:0]   reel_idx;
    logic               start;
    logic               early_stop;
    logic               lock_now;
    logic               last_lock;
    logic               all_equal;
    logic [SUM_W-1:0]   credit_sum;
    logic [CREDIT_W-1:0] credits_next;

    assign lever_rise = lever & ~lever_q;
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign start      = (state == IDLE) && lever_rise && (credits != '0);

`ifdef SLOT_EARLY_STOP_EN
    assign early_stop = (state == SPIN) && lever_rise;
`else
    assign early_stop = 1'b0;
`endif

    assign lock_now  = (state == SPIN) && ((spin_cnt == CNT_LAST) || early_stop);
    assign last_lock = lock_now && (reel_idx == IDX_LAST);

    // A single reel always compares equal to itself, so NUM_REELS == 1 always wins.
    always_comb begin
        all_equal = 1'b1;
        for (int i = 1; i < NUM_REELS; i++) begin
            if (reels[i*SYM_W +: SYM_W] != reels[SYM_W-1:0]) all_equal = 1'b0;
        end
    end

    // All credit sources are summed wide first so saturation sees the true total.
    always_comb begin
        credit_sum = SUM_W'(credits) + SUM_W'(coin) - SUM_W'(start);
        if (state == WIN) credit_sum = credit_sum + PAYOUT_EXT;
        credits_next = (credit_sum > CREDIT_MAX) ? CREDIT_W'(CREDIT_MAX)
                                                 : credit_sum[CREDIT_W-1:0];
    end

    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        win        = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = SPIN;
            SPIN: begin
                busy = 1'b1;
                if (last_lock) state_next = EVAL;
            end
            EVAL: begin
                busy       = 1'b1;
                state_next = all_equal ? WIN : IDLE;
            end
            WIN: begin
                win        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lever_q  <= 1'b0;
            lfsr     <= 16'hACE1;
            credits  <= '0;
            spin_cnt <= '0;
            reel_idx <= '0;
            reels    <= '0;
        end else begin
            lever_q <= lever;
            lfsr    <= {lfsr[14:0], lfsr_fb};
            credits <= credits_next;

            if (start) begin
                spin_cnt <= '0;
                reel_idx <= '0;
            end else if (state == SPIN) begin
                // Reels at or above reel_idx are still free; the lock edge takes one last sample.
                for (int i = 0; i < NUM_REELS; i++) begin
                    if (i >= int'(reel_idx)) reels[i*SYM_W +: SYM_W] <= lfsr[i*SYM_W +: SYM_W];
                end
                if (lock_now) begin
                    spin_cnt <= '0;
                    reel_idx <= reel_idx + IDX_W'(1);
                end else begin
                    spin_cnt <= spin_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/slot_machine_multi.md
SLOT_MACHINE_MULTI -- requirements
Module: slot_machine_multi

Interface
- REQ-001 SHALL have parameter NUM_REELS, default 3: number of reels; legal range 1..5.
- REQ-002 SHALL have parameter SYM_W, default 3: symbol width per reel; NUM_REELS*SYM_W SHALL be <= 16.
- REQ-003 SHALL have parameter SPIN_CYCLES, default 8: clock cycles between successive reel locks; legal range >= 2.
- REQ-004 SHALL have parameter CREDIT_W, default 8: credit counter width.
- REQ-005 SHALL have parameter PAYOUT, default 10: credits awarded on a win.
- REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
- REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-008 SHALL have port lever, input, 1 bit: level input; only its rising edge is acted on.
- REQ-009 SHALL have port coin, input, 1 bit: each cycle high adds one credit.
- REQ-010 SHALL have port reels, output, NUM_REELS*SYM_W bits: reel i occupies bits [i*SYM_W +: SYM_W].
- REQ-011 SHALL have port credits, output, CREDIT_W bits: current credit balance.
- REQ-012 SHALL have port busy, output, 1 bit: high in SPIN and EVAL.
- REQ-013 SHALL have port win, output, 1 bit: high exactly one cycle per winning spin.

Function
- REQ-014 SHALL detect the lever rising edge as lever & ~lever_q, where lever_q is lever registered by one cycle.
- REQ-015 SHALL advance a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) every cycle in every state.
- REQ-016 SHALL implement the states IDLE, SPIN, EVAL and WIN.
- REQ-017 SHALL, in IDLE, move to SPIN on the next edge when a lever rise coincides with credits > 0, and decrement credits by 1 at that same edge.
- REQ-018 SHALL, in IDLE, ignore a lever rise when credits == 0; state and credits stay unchanged.
- REQ-019 SHALL, in SPIN, update every unlocked reel i each cycle with LFSR bits [i*SYM_W +: SYM_W], while locked reels hold their value.
- REQ-020 SHALL, in SPIN, lock reel 0 first, then reels 1, 2, and so on, one per SPIN_CYCLES cycles, restarting the interval counter at each lock.
- REQ-021 SHALL go from SPIN to EVAL on the edge that locks the last reel, so a full spin lasts NUM_REELS*SPIN_CYCLES cycles.
- REQ-022 SHALL, in EVAL (one cycle), go to WIN if all reels are equal and to IDLE otherwise.
- REQ-023 SHALL, in WIN (one cycle), assert win, add PAYOUT to credits, and return to IDLE.
- REQ-024 SHALL hold the last stopped reel values on reels while in IDLE.
- REQ-025 SHALL saturate credits at 2^CREDIT_W-1 and never wrap.
- REQ-026 SHALL apply every credit change in the same edge as a single net sum (coin +1, start -1, payout +PAYOUT), then saturate; coin plus start in one cycle gives a net change of 0.
- REQ-027 SHALL ignore lever while in EVAL or WIN.
- REQ-028 SHALL treat NUM_REELS = 1 as always winning.

Reset
- REQ-029 SHALL, when reset is high at a clock edge, set state to IDLE, reels, credits, busy, win, lever_q and the interval counter to 0, and the LFSR to 16'hACE1.
- REQ-030 SHALL let reset override all other inputs, abort a spin in progress with no refund, and give a coin in the same cycle no effect.

Configuration
- REQ-031 SHALL, when SLOT_EARLY_STOP_EN is defined, treat a lever rise in SPIN as locking the next unlocked reel on the next edge and restarting the interval counter; a rise that locks the last reel goes to EVAL.
- REQ-032 SHALL, when SLOT_EARLY_STOP_EN is undefined, ignore lever in SPIN and include no early-stop logic.

Verification
- REQ-033 Bench SHALL cover: reset, then lever pulse with coin never high -> state stays IDLE, credits=0, busy=0.
- REQ-034 Bench SHALL cover: two coin cycles then lever rise -> credits 2->1, busy high for exactly 3*8+1=25 cycles, reels frozen afterwards.
- REQ-035 Bench SHALL cover: NUM_REELS=1, PAYOUT=10, one coin, one spin -> win pulses once, 8+1 cycles after busy rises; credits end at 10.
- REQ-036 Bench SHALL cover: CREDIT_W=4, credits=15, coin high plus a NUM_REELS=1 win payout -> credits stay at 15.
- REQ-037 Bench SHALL cover: reset asserted mid-SPIN with credits=4 -> next cycle state IDLE, credits=0, reels=0, busy=0.
- REQ-038 Bench SHALL cover: with SLOT_EARLY_STOP_EN defined, lever rise 2 cycles into SPIN -> reel 0 locks at cycle 3 and reel 1 locks 8 cycles later.
